// File: rtl/display_arbiter_pkg.sv
// rtl/display_arbiter_pkg.sv - shared display types: FSM states, owner encoding, hold counter width
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_COM  = 2'b10
  } owner_t;

  localparam int HOLD_CNT_W = 20;

  // The timer counts down to zero, so HOLD lasts load+1 cycles.
  function automatic logic [HOLD_CNT_W-1:0] hold_load(input int cycles);
    return HOLD_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// rtl/display_arbiter_hold_timer.sv - loadable down-counter with zero flag
module display_arbiter_hold_timer
  import display_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  load_i,
  input  logic [HOLD_CNT_W-1:0] load_val_i,
  output logic                  done_o
);

  logic [HOLD_CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - HOLD_CNT_W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin CPU/link arbiter for the display write port
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_cpu_i,
  input  logic [31:0] dato_cpu_i,
  output logic        ack_cpu_o,
  input  logic        req_com_i,
  input  logic [31:0] dato_com_i,
  output logic        ack_com_o,
  output logic        we_o,
  output logic [31:0] dato_o,
  output logic [1:0]  owner_o,
  output logic        busy_o
);

  state_t state_q;
  owner_t owner_q;
  logic   prio_cpu_q;
  logic   armed_q;
  logic   cpu_wins;
  logic   timer_load;
  logic   hold_done;

  assign cpu_wins   = req_cpu_i && (!req_com_i || prio_cpu_q);
  assign timer_load = (state_q == ST_GRANT);
  assign owner_o    = owner_q;

  display_arbiter_hold_timer u_hold_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (timer_load),
    .load_val_i (hold_load(HOLD_CYCLES)),
    .done_o     (hold_done)
  );

  // armed_q keeps the first edge after reset release from granting.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      prio_cpu_q <= 1'b1;
      armed_q    <= 1'b0;
      dato_o     <= '0;
      we_o       <= 1'b0;
      ack_cpu_o  <= 1'b0;
      ack_com_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      we_o      <= 1'b0;
      ack_cpu_o <= 1'b0;
      ack_com_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (armed_q && (req_cpu_i || req_com_i)) begin
            state_q <= ST_GRANT;
            busy_o  <= 1'b1;
            we_o    <= 1'b1;
            if (cpu_wins) begin
              ack_cpu_o  <= 1'b1;
              dato_o     <= dato_cpu_i;
              owner_q    <= OWN_CPU;
              prio_cpu_q <= 1'b0;
            end else begin
              ack_com_o  <= 1'b1;
              dato_o     <= dato_com_i;
              owner_q    <= OWN_COM;
              prio_cpu_q <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - table-driven self-checking bench for display_arbiter
module tb_display_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_cpu_i = 1'b0;
  logic [31:0] dato_cpu_i = '0;
  logic        ack_cpu_o;
  logic        req_com_i = 1'b0;
  logic [31:0] dato_com_i = '0;
  logic        ack_com_o;
  logic        we_o;
  logic [31:0] dato_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .req_cpu_i  (req_cpu_i),
    .dato_cpu_i (dato_cpu_i),
    .ack_cpu_o  (ack_cpu_o),
    .req_com_i  (req_com_i),
    .dato_com_i (dato_com_i),
    .ack_com_o  (ack_com_o),
    .we_o       (we_o),
    .dato_o     (dato_o),
    .owner_o    (owner_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic        rc;
    logic [31:0] dc;
    logic        rm;
    logic [31:0] dm;
    logic        we;
    logic        ac;
    logic        am;
    logic [31:0] dato;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst_n, input logic rc, input logic [31:0] dc,
                              input logic rm, input logic [31:0] dm,
                              input logic we, input logic ac, input logic am,
                              input logic [31:0] dato, input logic [1:0] own, input logic busy);
    vec_t v;
    v.rst_n = rst_n; v.rc = rc; v.dc = dc; v.rm = rm; v.dm = dm;
    v.we = we; v.ac = ac; v.am = am; v.dato = dato; v.own = own; v.busy = busy;
    vecs.push_back(v);
  endfunction

  function automatic void add_hold(input int n, input logic rc, input logic [31:0] dc,
                                   input logic rm, input logic [31:0] dm,
                                   input logic [31:0] dato, input logic [1:0] own);
    for (int i = 0; i < n; i++) add(1'b1, rc, dc, rm, dm, 1'b0, 1'b0, 1'b0, dato, own, 1'b1);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    // reset and single CPU write
    add(1'b0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    add(1'b1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    add(1'b1, 1, 32'h0000_1234, 0, 32'h0, 1, 1, 0, 32'h0000_1234, 2'b01, 1);
    add_hold(4, 0, 32'h0, 0, 32'h0, 32'h0000_1234, 2'b01);
    add(1'b1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0000_1234, 2'b01, 0);
    // fresh reset, then both requesters held: alternate every 6 cycles
    add(1'b0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    add(1'b1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    add(1'b1, 1, 32'hAAAA, 1, 32'h5555, 1, 1, 0, 32'hAAAA, 2'b01, 1);
    add_hold(4, 1, 32'hAAAA, 1, 32'h5555, 32'hAAAA, 2'b01);
    add(1'b1, 1, 32'hAAAA, 1, 32'h5555, 0, 0, 0, 32'hAAAA, 2'b01, 0);
    add(1'b1, 1, 32'hAAAA, 1, 32'h5555, 1, 0, 1, 32'h5555, 2'b10, 1);
    add_hold(4, 1, 32'hAAAA, 1, 32'h5555, 32'h5555, 2'b10);
    add(1'b1, 1, 32'hAAAA, 1, 32'h5555, 0, 0, 0, 32'h5555, 2'b10, 0);
    add(1'b1, 1, 32'hAAAA, 1, 32'h5555, 1, 1, 0, 32'hAAAA, 2'b01, 1);
    // link request arriving in HOLD cycle 3 waits for IDLE
    add_hold(3, 0, 32'h0, 0, 32'h0, 32'hAAAA, 2'b01);
    add_hold(1, 0, 32'h0, 1, 32'hBEEF, 32'hAAAA, 2'b01);
    add(1'b1, 0, 32'h0, 1, 32'hBEEF, 0, 0, 0, 32'hAAAA, 2'b01, 0);
    add(1'b1, 0, 32'h0, 1, 32'hBEEF, 1, 0, 1, 32'hBEEF, 2'b10, 1);
    // CPU request withdrawn during HOLD is dropped
    add_hold(1, 0, 32'h0, 0, 32'h0, 32'hBEEF, 2'b10);
    add_hold(1, 1, 32'h1111, 0, 32'h0, 32'hBEEF, 2'b10);
    add_hold(2, 0, 32'h0, 0, 32'h0, 32'hBEEF, 2'b10);
    add(1'b1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'hBEEF, 2'b10, 0);
    add(1'b1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'hBEEF, 2'b10, 0);
    // data changed during GRANT does not disturb dato_o
    add(1'b1, 1, 32'h2222, 0, 32'h0, 1, 1, 0, 32'h2222, 2'b01, 1);
    add_hold(2, 0, 32'h9999, 0, 32'h0, 32'h2222, 2'b01);

    @(negedge clk_i);
    for (int r = 0; r < vecs.size(); r++) begin
      reset_ni   = vecs[r].rst_n;
      req_cpu_i  = vecs[r].rc;
      dato_cpu_i = vecs[r].dc;
      req_com_i  = vecs[r].rm;
      dato_com_i = vecs[r].dm;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("we_o", r, 32'(we_o), 32'(vecs[r].we));
      chk("ack_cpu_o", r, 32'(ack_cpu_o), 32'(vecs[r].ac));
      chk("ack_com_o", r, 32'(ack_com_o), 32'(vecs[r].am));
      chk("dato_o", r, dato_o, vecs[r].dato);
      chk("owner_o", r, 32'(owner_o), 32'(vecs[r].own));
      chk("busy_o", r, 32'(busy_o), 32'(vecs[r].busy));
      chk("ack_exclusive", r, 32'(ack_cpu_o & ack_com_o), 32'h0);
    end

    // reset asserted in HOLD cycle 2 clears outputs without a clock edge
    reset_ni = 1'b0;
    #1;
    chk("rst_we", 900, 32'(we_o), 32'h0);
    chk("rst_busy", 900, 32'(busy_o), 32'h0);
    chk("rst_owner", 900, 32'(owner_o), 32'h0);
    chk("rst_dato", 900, dato_o, 32'h0);
    chk("rst_acks", 900, 32'({ack_cpu_o, ack_com_o}), 32'h0);
    req_com_i  = 1'b1;
    dato_com_i = 32'h0000_C0DE;
    @(negedge clk_i);
    chk("rst_held_we", 901, 32'(we_o), 32'h0);
    reset_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("first_edge_we", 902, 32'(we_o), 32'h0);
    chk("first_edge_ack", 902, 32'(ack_com_o), 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("post_rst_we", 903, 32'(we_o), 32'h1);
    chk("post_rst_ack_com", 903, 32'(ack_com_o), 32'h1);
    chk("post_rst_ack_cpu", 903, 32'(ack_cpu_o), 32'h0);
    chk("post_rst_dato", 903, dato_o, 32'h0000_C0DE);
    chk("post_rst_owner", 903, 32'(owner_o), 32'h2);
    req_com_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("post_rst_hold_busy", 904, 32'(busy_o), 32'h1);
    chk("post_rst_hold_we", 904, 32'(we_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
